// File: rtl/cmp_rr_scheduler_pkg.sv
// Shared definitions for the compare scheduler slice.
//   - FSM state encodings (kept as plain 2-bit constants so existing
//     consumers of the encoding keep working).
//   - clog2() helper used to cross-check the requester ID width.
package cmp_rr_scheduler_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Ceiling log2. Usable in constant expressions at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cmp_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter. Searches req upward starting at ptr,
// wrapping past N-1 back to 0, and raises exactly one grant bit for the
// first set request found. grant is all zero when req is all zero.
// Ports:
//   req    in   N   request vector
//   ptr    in   PW  highest-priority index for this search
//   grant  out  N   one-hot grant (or zero)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  // NOTE: every variable assigned in this block gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/n_bit_comparator.sv
// Unsigned N-bit magnitude comparator (purely combinational).
// Ports:
//   a, b  in   operands
//   lt    out  a <  b
//   gt    out  a >  b
//   eq    out  a == b
module n_bit_comparator #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt,
  output logic         gt,
  output logic         eq
);

  assign lt = (a <  b);
  assign gt = (a >  b);
  assign eq = (a == b);

endmodule

// File: rtl/cmp_rr_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit unsigned comparator among
// NREQ requesters. One compare is in flight at a time:
//   IDLE --grant--> CMP --> RESP --rsp_ready--> IDLE
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    in   NREQ        per-requester request valid
//   req_a/req_b  in   NREQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready    out  NREQ        one-hot grant (IDLE only)
//   rsp_valid    out  1           result valid
//   rsp_ready    in   1           consumer accepts result
//   rsp_id       out  IDW         requester owning the result
//   rsp_lt/gt/eq out  1           unsigned compare flags
//   busy         out  1           not in IDLE
//   done_cnt     out  16          completed responses, wrapping
module cmp_rr_scheduler
  import cmp_rr_scheduler_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_lt,
  output logic                  rsp_gt,
  output logic                  rsp_eq,
  output logic                  busy,
  output logic [15:0]           done_cnt
);

  if (IDW != clog2(NREQ) || NREQ < 2 || NREQ > 8) begin : g_param_check
    $error("cmp_rr_scheduler: NREQ must be 2..8 and IDW must equal clog2(NREQ)");
  end

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   next_ptr;
  logic             cmp_lt, cmp_gt, cmp_eq;

  rr_arbiter #(
    .N  (NREQ),
    .PW (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  n_bit_comparator #(
    .N (WIDTH)
  ) u_cmp (
    .a  (op_a),
    .b  (op_b),
    .lt (cmp_lt),
    .gt (cmp_gt),
    .eq (cmp_eq)
  );

  // Grants are only visible in IDLE and never while reset is held, so a
  // requester cannot see a handshake that the FSM will not take.
  assign req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
  assign busy      = (state != ST_IDLE);

  // One-hot grant to index; next pointer is one past the winner, wrapping
  // explicitly since NREQ need not be a power of two.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
    next_ptr = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_lt    <= 1'b0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
      done_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            op_a   <= req_a[grant_idx*WIDTH +: WIDTH];
            op_b   <= req_b[grant_idx*WIDTH +: WIDTH];
            id_q   <= grant_idx;
            rr_ptr <= next_ptr;
            state  <= ST_CMP;
          end
        end
        ST_CMP: begin
          rsp_lt    <= cmp_lt;
          rsp_gt    <= cmp_gt;
          rsp_eq    <= cmp_eq;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          // Flags and id are held untouched until the consumer accepts.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_rr_scheduler.sv
// Directed bench for cmp_rr_scheduler. Inputs change and outputs are
// sampled around the falling edge, away from the active rising edge.
module tb_cmp_rr_scheduler;

  localparam int W = 16;
  localparam int N = 4;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic             rsp_lt, rsp_gt, rsp_eq;
  logic             busy;
  logic [15:0]      done_cnt;

  int checks   = 0;
  int failures = 0;

  cmp_rr_scheduler #(.WIDTH(W), .NREQ(N), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_lt    (rsp_lt),
    .rsp_gt    (rsp_gt),
    .rsp_eq    (rsp_eq),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if ({rsp_lt, rsp_gt, rsp_eq} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {rsp_lt, rsp_gt, rsp_eq}); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done_cnt !== 16'h0000) begin failures++; $display("FAIL reset_done_cnt: got %h expected 0000", done_cnt); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    set_ops(0, 16'h0000, 16'h0001);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (busy !== 1'b1 || req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL single_cmp_state: busy=%b req_ready=%b rsp_valid=%b expected 1/0000/0", busy, req_ready, rsp_valid);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_lt, rsp_gt, rsp_eq} !== 3'b100) begin
      failures++; $display("FAIL single_rsp: valid=%b id=%0d flags=%b expected 1/0/100", rsp_valid, rsp_id, {rsp_lt, rsp_gt, rsp_eq});
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || done_cnt !== 16'd1 || busy !== 1'b0) begin
      failures++; $display("FAIL single_done: valid=%b done_cnt=%0d busy=%b expected 0/1/0", rsp_valid, done_cnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_flags [4];
    int exp_id;
    exp_flags = '{3'b001, 3'b010, 3'b100, 3'b001};
    apply_reset();
    set_ops(0, 16'h1001, 16'h1001);
    set_ops(1, 16'hb000, 16'ha019);
    set_ops(2, 16'hff00, 16'hffff);
    set_ops(3, 16'hffff, 16'hffff);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_id)) begin
        failures++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, 4'b0001 << exp_id);
      end
      @(negedge clk);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || {rsp_lt, rsp_gt, rsp_eq} !== exp_flags[exp_id]) begin
        failures++; $display("FAIL rr_rsp_%0d: valid=%b id=%0d flags=%b expected 1/%0d/%b",
                             k, rsp_valid, rsp_id, {rsp_lt, rsp_gt, rsp_eq}, exp_id, exp_flags[exp_id]);
      end
      @(negedge clk);
    end
    req_valid = '0;
    checks++; if (done_cnt !== 16'd5) begin failures++; $display("FAIL rr_done_cnt: got %0d expected 5", done_cnt); end
  endtask

  task automatic test_backpressure();
    // rr_ptr is 1 here (last grant went to requester 0).
    set_ops(0, 16'h0005, 16'h0003);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_grant: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0010;
    set_ops(0, 16'h0000, 16'h0009);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_lt, rsp_gt, rsp_eq} !== 3'b010 || req_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_hold_%0d: valid=%b id=%0d flags=%b req_ready=%b expected 1/0/010/0000",
                             c, rsp_valid, rsp_id, {rsp_lt, rsp_gt, rsp_eq}, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 16'd6) begin
      failures++; $display("FAIL bp_release: valid=%b busy=%b done_cnt=%0d expected 0/0/6", rsp_valid, busy, done_cnt);
    end
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_next_grant: got %b expected 0010", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_wrap_fairness();
    apply_reset();
    set_ops(0, 16'h0007, 16'h0007);
    set_ops(2, 16'h0001, 16'h0002);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL wrap_first_grant: got %b expected 0100", req_ready); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wrap_grant_req0: got %b expected 0001", req_ready); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_id !== 2'd0 || {rsp_lt, rsp_gt, rsp_eq} !== 3'b001) begin
      failures++; $display("FAIL wrap_rsp_req0: id=%0d flags=%b expected 0/001", rsp_id, {rsp_lt, rsp_gt, rsp_eq});
    end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL fair_grant_req2: got %b expected 0100", req_ready); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_id !== 2'd2 || {rsp_lt, rsp_gt, rsp_eq} !== 3'b100) begin
      failures++; $display("FAIL fair_rsp_req2: id=%0d flags=%b expected 2/100", rsp_id, {rsp_lt, rsp_gt, rsp_eq});
    end
    req_valid = '0;
    @(negedge clk);
    checks++; if (done_cnt !== 16'd3) begin failures++; $display("FAIL wrap_done_cnt: got %0d expected 3", done_cnt); end
  endtask

  task automatic test_async_reset();
    // rr_ptr is 3 and done_cnt is 3 here.
    set_ops(3, 16'h8000, 16'h0001);
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL arst_in_cmp: busy=%b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_cnt !== 16'd0 || req_ready !== 4'b0000 ||
                  rsp_id !== 2'd0 || {rsp_lt, rsp_gt, rsp_eq} !== 3'b000) begin
      failures++; $display("FAIL arst_outputs: busy=%b valid=%b done_cnt=%0d req_ready=%b id=%0d flags=%b expected all zero",
                           busy, rsp_valid, done_cnt, req_ready, rsp_id, {rsp_lt, rsp_gt, rsp_eq});
    end
    req_valid = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL arst_first_grant: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_id !== 2'd1 || {rsp_lt, rsp_gt, rsp_eq} !== 3'b010) begin
      failures++; $display("FAIL arst_rsp: id=%0d flags=%b expected 1/010", rsp_id, {rsp_lt, rsp_gt, rsp_eq});
    end
    @(negedge clk);
    checks++; if (done_cnt !== 16'd1) begin failures++; $display("FAIL arst_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_done_wrap();
    force dut.done_cnt = 16'hFFFF;
    #1 release dut.done_cnt;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || done_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_pre: valid=%b done_cnt=%h expected 1/ffff", rsp_valid, done_cnt);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || done_cnt !== 16'h0000) begin
      failures++; $display("FAIL wrap_post: valid=%b done_cnt=%h expected 0/0000", rsp_valid, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_fairness();
    test_async_reset();
    test_done_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_rr_scheduler.md
Name: cmp_rr_scheduler

Overview:
- Shares one combinational WIDTH-bit magnitude comparator (existing n_bit_comparator, outputs lt/gt/eq) among NREQ requesters.
- Round-robin arbitration; operands and requester ID are captured into registers, compared, and the result is returned over a valid/ready response channel.
- One compare in flight at a time; sits between multiple control engines and the shared comparator datapath.

Parameters:
- WIDTH, 16, operand width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  flattened operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  flattened operand B, same packing.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester the result belongs to.
- rsp_lt  out  1  A < B (unsigned).
- rsp_gt  out  1  A > B.
- rsp_eq  out  1  A == B.
- busy  out  1  high in any state other than IDLE.
- done_cnt  out  16  count of completed responses; wraps 0xFFFF -> 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; rsp_valid=0; rsp_id=0; rsp_lt/gt/eq=0; req_ready=0; busy=0; done_cnt=0; operand registers=0.
- FSM states:
  - IDLE -> CMP on any req_valid.
  - CMP -> RESP unconditionally.
  - RESP -> IDLE when rsp_ready.
- IDLE:
  - req_ready is combinational: one-hot on the first requester with req_valid set, searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - All req_ready bits are 0 when no request is valid, and 0 in CMP and RESP.
  - On a grant to requester g: latch op_a, op_b and id=g; set rr_ptr to (g+1) mod NREQ.
- CMP: comparator is driven from op_a/op_b; lt/gt/eq are registered into rsp_*; rsp_id=id; rsp_valid is set at the end of the cycle.
- RESP:
  - rsp_valid=1.
  - rsp_* stay stable while rsp_ready is low (no drop, no change).
  - On rsp_ready: rsp_valid clears next cycle and done_cnt increments.
- Latency:
  - Grant at edge T gives rsp_valid high after edge T+2.
  - Minimum issue interval is 3 cycles; there is no back-to-back overlap.
- Requesters must hold valid and operands until granted; the scheduler never drops a request.
- Exactly one of lt/gt/eq is 1 while rsp_valid=1. All three are 0 after reset until the first result.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants.
- rst_n asserted mid-operation (CMP or RESP) aborts immediately to reset values; the in-flight result is lost and done_cnt returns to 0.
- Comparison is unsigned WIDTH-bit.
- If rsp_ready is already high on entry to RESP, the state is held for exactly one cycle.

Decomposition:
- Shared package/header: state encodings (ST_IDLE=2'd0, ST_CMP=2'd1, ST_RESP=2'd2) and a CLOG2 helper function/macro used for IDW checking.
- One sub-module, rr_arbiter (combinational priority rotate: inputs req, ptr; output one-hot grant). It is reusable by other shared-resource blocks.
- Existing n_bit_comparator is instantiated unchanged with WIDTH-bit operands.

Test Plan:
- Reset then a single request: req_valid=4'b0001, A=16'h0000, B=16'h0001, rsp_ready=1 -> grant[0] at T, rsp_valid at T+2 with id=0, lt=1, gt=0, eq=0; done_cnt=1.
- Round-robin: all four valid constantly; operands req0 16'h1001/16'h1001, req1 16'hb000/16'ha019, req2 16'hff00/16'hffff, req3 16'hffff/16'hffff -> grant order 0,1,2,3,0 and results eq, gt, lt, eq.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_* held constant, req_ready all 0, no new grant; rsp_ready=1 -> IDLE next cycle, then next grant.
- Pointer wrap and fairness: rr_ptr=3 after granting req2; valid=4'b0101 -> grant req0 (wrap), then req2.
- Async reset mid-CMP: drop rst_n between edges -> all outputs 0 immediately, done_cnt=0; first grant after release goes to the lowest valid index.
- done_cnt wrap: force 65536 completions (or preload via hierarchical deposit to 16'hFFFF) -> next completion gives done_cnt=16'h0000.
